// File: rtl/mem_port_arbiter.sv
// Purpose: shares one single-port RAM between instruction fetch and load/store, round-robin on ties.
// Latency: load/fetch ack 3 cycles after the request is sampled, store 2, misaligned error 1.
// Backpressure: a losing or in-flight requester holds req and its inputs stable until its ack pulse.
module mem_port_arbiter #(
  parameter int ADDR_W = 17
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              f_req,
  input  logic [ADDR_W-1:0] f_addr,
  output logic              f_ack,
  output logic              f_err,
  output logic [31:0]       f_rdata,
  input  logic              ls_req,
  input  logic              ls_we,
  input  logic [1:0]        ls_size,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [31:0]       ls_wdata,
  output logic              ls_ack,
  output logic              ls_err,
  output logic [31:0]       ls_rdata,
  output logic              mem_en,
  output logic [3:0]        mem_we,
  output logic [ADDR_W-3:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, DONE} state_t;

  localparam logic GRANT_F  = 1'b0;
  localparam logic GRANT_LS = 1'b1;

  state_t state, state_nxt;

  // Transaction context captured when IDLE accepts a request.
  logic              last_grant;
  logic              sel;
  logic              store_r;
  logic              err_r;
  logic [1:0]        size_r;
  logic [ADDR_W-1:0] addr_r;
  logic [3:0]        we_r;
  logic [31:0]       wdata_r;

  logic              pick_ls;
  logic              pending;
  logic              win_misal;
  logic [ADDR_W-1:0] win_addr;
  logic [1:0]        win_size;
  logic              win_store;
  logic [3:0]        lane_we;
  logic [31:0]       lane_wdata;
  logic [31:0]       rd_shift;
  logic [31:0]       rd_align;

  // LS wins when it is the only requester or when fetch was granted last.
  assign pending   = f_req | ls_req;
  assign pick_ls   = ls_req & (~f_req | (last_grant == GRANT_F));
  assign win_addr  = pick_ls ? ls_addr : f_addr;
  assign win_size  = pick_ls ? ls_size : 2'b10;
  assign win_store = pick_ls & ls_we;

  // Alignment check for the winning request; bytes can never be misaligned.
  always_comb begin
    win_misal = 1'b0;
    case (win_size)
      2'b00:   win_misal = 1'b0;
      2'b01:   win_misal = win_addr[0];
      default: win_misal = |win_addr[1:0];
    endcase
  end

  // Byte-lane enables and replicated store data so the RAM sees data on every lane it writes.
  always_comb begin
    lane_we    = 4'b1111;
    lane_wdata = ls_wdata;
    case (ls_size)
      2'b00: begin
        lane_we    = 4'b0001 << ls_addr[1:0];
        lane_wdata = {4{ls_wdata[7:0]}};
      end
      2'b01: begin
        lane_we    = ls_addr[1] ? 4'b1100 : 4'b0011;
        lane_wdata = {2{ls_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  // Right-align read data onto the low lanes and zero everything above the access size.
  always_comb begin
    rd_shift = mem_rdata >> {addr_r[1:0], 3'b000};
    case (size_r)
      2'b00:   rd_align = {24'h0, rd_shift[7:0]};
      2'b01:   rd_align = {16'h0, rd_shift[15:0]};
      default: rd_align = rd_shift;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next-state and output decode; RAM outputs are zero except in ISSUE.
  always_comb begin
    state_nxt = state;
    mem_en    = 1'b0;
    mem_we    = 4'b0000;
    mem_addr  = '0;
    mem_wdata = 32'h0;
    f_ack     = 1'b0;
    f_err     = 1'b0;
    ls_ack    = 1'b0;
    ls_err    = 1'b0;
    case (state)
      IDLE: begin
        if (pending) state_nxt = win_misal ? DONE : ISSUE;
      end
      ISSUE: begin
        mem_en    = 1'b1;
        mem_we    = we_r;
        mem_addr  = addr_r[ADDR_W-1:2];
        mem_wdata = wdata_r;
        state_nxt = store_r ? DONE : CAPTURE;
      end
      CAPTURE: begin
        state_nxt = DONE;
      end
      DONE: begin
        if (sel == GRANT_LS) begin
          ls_ack = 1'b1;
          ls_err = err_r;
        end else begin
          f_ack = 1'b1;
          f_err = err_r;
        end
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Transaction context, read-data registers and round-robin history.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_grant <= GRANT_LS;
      sel        <= GRANT_F;
      store_r    <= 1'b0;
      err_r      <= 1'b0;
      size_r     <= 2'b00;
      addr_r     <= '0;
      we_r       <= 4'b0000;
      wdata_r    <= 32'h0;
      f_rdata    <= 32'h0;
      ls_rdata   <= 32'h0;
    end else begin
      case (state)
        IDLE: begin
          if (pending) begin
            sel     <= pick_ls;
            store_r <= win_store;
            err_r   <= win_misal;
            size_r  <= win_size;
            addr_r  <= win_addr;
            we_r    <= win_store ? lane_we : 4'b0000;
            wdata_r <= win_store ? lane_wdata : 32'h0;
          end
        end
        CAPTURE: begin
          if (sel == GRANT_LS) ls_rdata <= rd_align;
          else                 f_rdata  <= rd_align;
        end
        DONE: begin
          last_grant <= sel;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus randomized traffic against a byte-level memory model.
// The RAM model answers mem_en with one cycle of read latency and byte-lane writes.
// The reference tracks memory as bytes and derives lanes, data and timing from access size and address.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        f_req = 1'b0;
  logic [16:0] f_addr = '0;
  logic        f_ack, f_err;
  logic [31:0] f_rdata;
  logic        ls_req = 1'b0;
  logic        ls_we = 1'b0;
  logic [1:0]  ls_size = 2'b00;
  logic [16:0] ls_addr = '0;
  logic [31:0] ls_wdata = '0;
  logic        ls_ack, ls_err;
  logic [31:0] ls_rdata;
  logic        mem_en;
  logic [3:0]  mem_we;
  logic [14:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;

  int n_chk = 0;
  int n_pass = 0;

  mem_port_arbiter #(.ADDR_W(17)) dut (
    .clk(clk), .reset_n(reset_n),
    .f_req(f_req), .f_addr(f_addr), .f_ack(f_ack), .f_err(f_err), .f_rdata(f_rdata),
    .ls_req(ls_req), .ls_we(ls_we), .ls_size(ls_size), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
    .ls_ack(ls_ack), .ls_err(ls_err), .ls_rdata(ls_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Power-up RAM contents; two words are pinned for the directed scenarios.
  function automatic logic [31:0] init_word(input int w);
    if (w == 32'h41) return 32'hDEADBEEF;
    if (w == 4) return 32'h80017FFF;
    return (w * 32'h01000193) ^ 32'h5A5A1234;
  endfunction

  // RAM model: word-addressed, byte-lane writes, registered read data.
  logic [31:0] ram_w [int];
  logic [31:0] ram_cur;
  always @(posedge clk) begin
    if (mem_en) begin
      ram_cur = ram_w.exists(int'(mem_addr)) ? ram_w[int'(mem_addr)] : init_word(int'(mem_addr));
      if (mem_we == 4'b0000) begin
        mem_rdata <= ram_cur;
      end else begin
        for (int l = 0; l < 4; l++)
          if (mem_we[l]) ram_cur[8*l +: 8] = mem_wdata[8*l +: 8];
        ram_w[int'(mem_addr)] = ram_cur;
      end
    end
  end

  // Reference model state: byte memory, expected read registers, last granted port.
  logic [7:0]  ref_b [int];
  logic [31:0] exp_f = '0;
  logic [31:0] exp_ls = '0;
  bit          last_ls = 1'b1;

  logic        e_err;
  int          e_cyc, e_en;
  logic [3:0]  e_we;
  logic [31:0] e_wd, e_rd;

  int          t_cyc, t_en, t_wrong;
  logic        t_err;
  logic [3:0]  t_we;
  logic [14:0] t_ma;
  logic [31:0] t_wd, t_rd;

  function automatic logic [7:0] mem_byte(input int a);
    logic [31:0] w;
    if (ref_b.exists(a)) return ref_b[a];
    w = init_word(a >> 2);
    return w[8*(a%4) +: 8];
  endfunction

  function automatic int nbytes(input logic [1:0] s);
    return (s == 2'b00) ? 1 : (s == 2'b01) ? 2 : 4;
  endfunction

  // Expected outcome of one transaction; updates the model memory and read registers.
  task automatic model(input bit is_ls, input bit we, input logic [1:0] sz, input logic [16:0] a,
                       input logic [31:0] wd);
    int n;
    logic [31:0] v;
    n = is_ls ? nbytes(sz) : 4;
    e_err = (int'(a) % n) != 0;
    e_we = 4'b0000;
    e_wd = '0;
    if (e_err) begin
      e_cyc = 1; e_en = 0;
    end else if (is_ls && we) begin
      e_cyc = 2; e_en = 1;
      for (int i = 0; i < n; i++) begin
        e_we[(int'(a) + i) % 4] = 1'b1;
        ref_b[int'(a) + i] = wd[8*i +: 8];
      end
      for (int l = 0; l < 4; l++) e_wd[8*l +: 8] = wd[8*(l % n) +: 8];
    end else begin
      e_cyc = 3; e_en = 1;
      v = '0;
      for (int i = 0; i < n; i++) v[8*i +: 8] = mem_byte(int'(a) + i);
      if (is_ls) exp_ls = v;
      else       exp_f = v;
    end
    e_rd = is_ls ? exp_ls : exp_f;
  endtask

  // Drives one request from IDLE, observes until its ack (bounded), then returns to IDLE.
  task automatic txn(input bit is_ls, input bit we, input logic [1:0] sz, input logic [16:0] a,
                     input logic [31:0] wd);
    bit done;
    done = 1'b0; t_cyc = 0; t_en = 0; t_wrong = 0; t_err = 1'b0;
    t_we = '0; t_ma = '0; t_wd = '0; t_rd = '0;
    if (is_ls) begin
      ls_we = we; ls_size = sz; ls_addr = a; ls_wdata = wd; ls_req = 1'b1;
    end else begin
      f_addr = a; f_req = 1'b1;
    end
    while (!done && t_cyc < 20) begin
      @(posedge clk); #1;
      t_cyc++;
      if (mem_en) begin
        t_en++; t_we = mem_we; t_ma = mem_addr; t_wd = mem_wdata;
      end
      if (is_ls ? f_ack : ls_ack) t_wrong++;
      if (is_ls ? ls_ack : f_ack) begin
        done = 1'b1;
        t_err = is_ls ? ls_err : f_err;
        t_rd = is_ls ? ls_rdata : f_rdata;
      end
    end
    f_req = 1'b0; ls_req = 1'b0;
    if (!done) t_cyc = 99;
    last_ls = is_ls;
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    @(posedge clk); @(posedge clk);
    @(negedge clk) reset_n = 1'b1;
    last_ls = 1'b1; exp_f = '0; exp_ls = '0;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    n_chk++;
    if ({f_ack, f_err, ls_ack, ls_err, mem_en, mem_we, mem_addr, mem_wdata, f_rdata, ls_rdata} !== '0)
      $display("FAIL reset_outputs f_rdata=%h ls_rdata=%h mem_en=%b ack=%b%b want all zero",
               f_rdata, ls_rdata, mem_en, f_ack, ls_ack);
    else n_pass++;
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk); #1;
    n_chk++;
    if ({f_ack, ls_ack, mem_en} !== 3'b000)
      $display("FAIL idle_quiet f_ack=%b ls_ack=%b mem_en=%b want 000", f_ack, ls_ack, mem_en);
    else n_pass++;
  endtask

  task automatic test_fetch();
    model(1'b0, 1'b0, 2'b10, 17'h00104, 32'h0);
    txn(1'b0, 1'b0, 2'b10, 17'h00104, 32'h0);
    n_chk++; if (t_cyc !== 3) $display("FAIL fetch_ack_cycle got %0d want 3", t_cyc); else n_pass++;
    n_chk++; if (t_en !== 1 || t_ma !== 15'h41) $display("FAIL fetch_mem got en=%0d addr=%h want 1 041", t_en, t_ma); else n_pass++;
    n_chk++; if (t_rd !== 32'hDEADBEEF || t_err !== 1'b0) $display("FAIL fetch_rdata got %h err=%b want deadbeef 0", t_rd, t_err); else n_pass++;
  endtask

  task automatic test_half_load();
    model(1'b1, 1'b0, 2'b01, 17'h00012, 32'h0);
    txn(1'b1, 1'b0, 2'b01, 17'h00012, 32'h0);
    n_chk++; if (t_cyc !== 3 || t_ma !== 15'h4) $display("FAIL half_load_timing got cyc=%0d addr=%h want 3 004", t_cyc, t_ma); else n_pass++;
    n_chk++; if (t_rd !== 32'h00008001) $display("FAIL half_load_data got %h want 00008001", t_rd); else n_pass++;
    model(1'b1, 1'b0, 2'b01, 17'h00011, 32'h0);
    txn(1'b1, 1'b0, 2'b01, 17'h00011, 32'h0);
    n_chk++; if (t_cyc !== 1 || t_err !== 1'b1) $display("FAIL half_misaligned got cyc=%0d err=%b want 1 1", t_cyc, t_err); else n_pass++;
    n_chk++; if (t_en !== 0 || t_rd !== 32'h00008001) $display("FAIL half_misaligned_side got en=%0d rdata=%h want 0 00008001", t_en, t_rd); else n_pass++;
  endtask

  task automatic test_byte_store();
    model(1'b1, 1'b1, 2'b00, 17'h00013, 32'h000000A5);
    txn(1'b1, 1'b1, 2'b00, 17'h00013, 32'h000000A5);
    n_chk++; if (t_cyc !== 2 || t_err !== 1'b0) $display("FAIL byte_store_cycle got %0d err=%b want 2 0", t_cyc, t_err); else n_pass++;
    n_chk++; if (t_we !== 4'b1000 || t_wd !== 32'hA5A5A5A5 || t_ma !== 15'h4)
      $display("FAIL byte_store_lanes got we=%b wd=%h addr=%h want 1000 a5a5a5a5 004", t_we, t_wd, t_ma); else n_pass++;
    model(1'b1, 1'b0, 2'b00, 17'h00013, 32'h0);
    txn(1'b1, 1'b0, 2'b00, 17'h00013, 32'h0);
    n_chk++; if (t_rd !== 32'h000000A5 || t_cyc !== 3) $display("FAIL byte_load_back got %h cyc=%0d want 000000a5 3", t_rd, t_cyc); else n_pass++;
  endtask

  task automatic test_fetch_err();
    model(1'b0, 1'b0, 2'b10, 17'h00002, 32'h0);
    txn(1'b0, 1'b0, 2'b10, 17'h00002, 32'h0);
    n_chk++; if (t_cyc !== 1 || t_err !== 1'b1 || t_en !== 0)
      $display("FAIL fetch_misaligned got cyc=%0d err=%b en=%0d want 1 1 0", t_cyc, t_err, t_en); else n_pass++;
    n_chk++; if (t_rd !== 32'hDEADBEEF) $display("FAIL fetch_err_hold got %h want deadbeef", t_rd); else n_pass++;
  endtask

  task automatic test_random(input int n);
    bit is_ls, we;
    int kind;
    logic [1:0]  sz;
    logic [16:0] a;
    logic [31:0] wd;
    for (int k = 0; k < n; k++) begin
      kind = $urandom_range(0, 2);
      is_ls = (kind != 0);
      we = (kind == 2);
      sz = is_ls ? 2'($urandom_range(0, 3)) : 2'b10;
      a = 17'($urandom_range(0, 63));
      if ($urandom_range(0, 1) == 0) a[1:0] = 2'b00;
      if ($urandom_range(0, 1) == 0) a = a | 17'h1FFC0;
      wd = $urandom;
      model(is_ls, we, sz, a, wd);
      txn(is_ls, we, sz, a, wd);
      n_chk++; if (t_err !== e_err || t_cyc !== e_cyc)
        $display("FAIL rnd%0d_resp got err=%b cyc=%0d want %b %0d", k, t_err, t_cyc, e_err, e_cyc); else n_pass++;
      n_chk++; if (t_en !== e_en || t_wrong !== 0)
        $display("FAIL rnd%0d_strobes got en=%0d wrong_ack=%0d want %0d 0", k, t_en, t_wrong, e_en); else n_pass++;
      n_chk++; if (t_rd !== e_rd) $display("FAIL rnd%0d_rdata got %h want %h", k, t_rd, e_rd); else n_pass++;
      if (!e_err) begin
        n_chk++; if (t_ma !== 15'(a >> 2) || t_we !== e_we || t_wd !== e_wd)
          $display("FAIL rnd%0d_mem got addr=%h we=%b wd=%h want %h %b %h", k, t_ma, t_we, t_wd, 15'(a >> 2), e_we, e_wd);
        else n_pass++;
      end
    end
  endtask

  // Both ports held for n_txn transactions: grants alternate, one ack every 4 cycles.
  task automatic test_contention(input int n_txn);
    logic [16:0] fa, la;
    logic [1:0]  sz;
    logic [31:0] ef, el;
    int acks, cyc;
    bit exp_port;
    fa = 17'($urandom_range(0, 31) * 4);
    la = 17'($urandom_range(0, 15) * 4);
    sz = 2'($urandom_range(0, 3));
    model(1'b0, 1'b0, 2'b10, fa, 32'h0); ef = e_rd;
    model(1'b1, 1'b0, sz, la, 32'h0);    el = e_rd;
    acks = 0; cyc = 0;
    exp_port = !last_ls;
    f_addr = fa; f_req = 1'b1;
    ls_we = 1'b0; ls_size = sz; ls_addr = la; ls_wdata = $urandom; ls_req = 1'b1;
    while (acks < n_txn && cyc < 20 * n_txn) begin
      @(posedge clk); #1;
      cyc++;
      if (f_ack || ls_ack) begin
        n_chk++; if ((f_ack && ls_ack) || ls_ack !== exp_port)
          $display("FAIL contend_grant%0d got f_ack=%b ls_ack=%b want ls=%b", acks, f_ack, ls_ack, exp_port); else n_pass++;
        n_chk++; if (cyc !== 4 * acks + 3) $display("FAIL contend_time%0d got %0d want %0d", acks, cyc, 4 * acks + 3); else n_pass++;
        n_chk++; if (ls_ack ? (ls_rdata !== el) : (f_rdata !== ef))
          $display("FAIL contend_data%0d got f=%h ls=%h want f=%h ls=%h", acks, f_rdata, ls_rdata, ef, el); else n_pass++;
        last_ls = ls_ack;
        exp_port = !ls_ack;
        acks++;
        if (acks == n_txn) begin f_req = 1'b0; ls_req = 1'b0; end
      end
    end
    f_req = 1'b0; ls_req = 1'b0;
    n_chk++; if (acks !== n_txn) $display("FAIL contend_count got %0d want %0d", acks, n_txn); else n_pass++;
    @(posedge clk); #1;
  endtask

  // Reset asserted while a load is in CAPTURE; the held request must then restart from scratch.
  task automatic test_reset_mid();
    int cyc, en_cyc;
    bit acked;
    ls_we = 1'b0; ls_size = 2'b10; ls_addr = 17'h00104; ls_wdata = '0; ls_req = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset_n = 1'b0;
    #1;
    n_chk++;
    if ({f_ack, f_err, ls_ack, ls_err, mem_en, mem_we, mem_addr, mem_wdata, f_rdata, ls_rdata} !== '0)
      $display("FAIL reset_mid_outputs ls_ack=%b mem_en=%b f_rdata=%h ls_rdata=%h want all zero", ls_ack, mem_en, f_rdata, ls_rdata);
    else n_pass++;
    @(posedge clk); #1;
    n_chk++; if ({ls_ack, f_ack, mem_en} !== 3'b000)
      $display("FAIL reset_mid_no_ack got ls_ack=%b f_ack=%b mem_en=%b want 000", ls_ack, f_ack, mem_en); else n_pass++;
    @(negedge clk) reset_n = 1'b1;
    last_ls = 1'b1; exp_f = '0; exp_ls = '0;
    model(1'b1, 1'b0, 2'b10, 17'h00104, 32'h0);
    cyc = 0; en_cyc = 0; acked = 1'b0;
    while (!acked && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
      if (mem_en && en_cyc == 0) en_cyc = cyc;
      if (ls_ack) acked = 1'b1;
    end
    n_chk++; if (!acked || cyc !== 3 || en_cyc !== 1)
      $display("FAIL reset_restart_timing got ack_cyc=%0d en_cyc=%0d acked=%b want 3 1 1", cyc, en_cyc, acked); else n_pass++;
    n_chk++; if (ls_rdata !== e_rd) $display("FAIL reset_restart_data got %h want %h", ls_rdata, e_rd); else n_pass++;
    ls_req = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_half_load();
    test_byte_store();
    test_fetch_err();
    test_random(80);
    test_contention(6);
    do_reset();
    test_contention(3);
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
